// File: rtl/im_arb.sv
// im_arb: instruction-memory arbiter between a fetch port and a boot loader.
//
// Single-port memory shared by two requesters. In BOOT only the loader is
// served; after the one-cycle l_boot_done_i pulse the block stays in RUN,
// where fetch has fixed priority unless the loader has waited STARVE_MAX
// consecutive cycles. Grants are combinational; read responses (data, valid,
// error) are registered and appear exactly one cycle after the grant.
//
// Ports:
//   clk_i, reset_ni                         clock, async active-low reset
//   f_req_i, f_addr_i                       fetch request, byte address
//   f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o fetch grant / response
//   l_req_i, l_we_i, l_addr_i, l_wdata_i    loader request
//   l_boot_done_i                           loader finished (BOOT -> RUN)
//   l_gnt_o, l_rvalid_o, l_rdata_o, l_err_o loader grant / read response
//   m_addr_o, m_we_o, m_wdata_o, m_rdata_i  memory word port
//
// Optional feature: define IM_ARB_RANGE_CHK_EN to flag out-of-range or
// misaligned addresses (granted, write suppressed, data 0, err with rvalid).
// Without it the word index simply wraps modulo SIZE and err is always 0.
module im_arb #(
    parameter int          SIZE       = 4096,
    parameter logic [31:0] BASE       = 32'h0000_3000,
    parameter int          STARVE_MAX = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    f_req_i,
    input  logic [31:0]             f_addr_i,
    output logic                    f_gnt_o,
    output logic                    f_rvalid_o,
    output logic [31:0]             f_rdata_o,
    output logic                    f_err_o,
    input  logic                    l_req_i,
    input  logic                    l_we_i,
    input  logic [31:0]             l_addr_i,
    input  logic [31:0]             l_wdata_i,
    input  logic                    l_boot_done_i,
    output logic                    l_gnt_o,
    output logic                    l_rvalid_o,
    output logic [31:0]             l_rdata_o,
    output logic                    l_err_o,
    output logic [$clog2(SIZE)-1:0] m_addr_o,
    output logic                    m_we_o,
    output logic [31:0]             m_wdata_o,
    input  logic [31:0]             m_rdata_i
);
    localparam int          AW   = $clog2(SIZE);
    localparam int          SW   = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] SPAN = 32'(4 * SIZE);
`ifdef IM_ARB_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef enum logic {BOOT, RUN} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            f_rvalid_q, f_err_q, l_rvalid_q, l_err_q;
    logic [31:0]     f_rdata_q, l_rdata_q;
    logic [31:0]     f_off, l_off;
    logic            f_bad, l_bad, run, l_win, f_gnt, l_gnt, l_rd;

    always_comb begin
        f_off    = f_addr_i - BASE;
        l_off    = l_addr_i - BASE;
        // An address below BASE wraps to a huge offset, so one compare covers both ends.
        f_bad    = CHK && ((f_off >= SPAN) || (f_addr_i[1:0] != 2'b00));
        l_bad    = CHK && ((l_off >= SPAN) || (l_addr_i[1:0] != 2'b00));
        run      = (state_q == RUN);
        l_win    = (starve_q == SW'(STARVE_MAX));
        f_gnt    = run && f_req_i && !(l_win && l_req_i);
        l_gnt    = l_req_i && (!run || !f_req_i || l_win);
        // Bad-address writes still answer with an error response.
        l_rd     = l_gnt && (!l_we_i || l_bad);
        state_d  = (state_q == BOOT && l_boot_done_i) ? RUN : state_q;
        starve_d = l_gnt ? '0 :
                   (run && l_req_i && !l_win) ? starve_q + 1'b1 : starve_q;
        m_addr_o = f_gnt ? f_off[AW+1:2] : l_gnt ? l_off[AW+1:2] : '0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= BOOT;
            starve_q   <= '0;
            f_rvalid_q <= 1'b0;
            f_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            l_rvalid_q <= 1'b0;
            l_err_q    <= 1'b0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            f_rvalid_q <= f_gnt;
            f_err_q    <= f_gnt && f_bad;
            l_rvalid_q <= l_rd;
            l_err_q    <= l_gnt && l_bad;
            if (f_gnt)
                f_rdata_q <= f_bad ? '0 : m_rdata_i;
            if (l_rd)
                l_rdata_q <= l_bad ? '0 : m_rdata_i;
        end
    end

    assign f_gnt_o    = f_gnt;
    assign l_gnt_o    = l_gnt;
    assign f_rvalid_o = f_rvalid_q;
    assign f_rdata_o  = f_rdata_q;
    assign f_err_o    = f_err_q;
    assign l_rvalid_o = l_rvalid_q;
    assign l_rdata_o  = l_rdata_q;
    assign l_err_o    = l_err_q;
    assign m_we_o     = l_gnt && l_we_i && !l_bad;
    assign m_wdata_o  = l_wdata_i;
endmodule

// File: tb/tb_im_arb.sv
// tb_im_arb: directed vector table plus multi-cycle sequences for im_arb.
module tb_im_arb;
`ifdef IM_ARB_RANGE_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_boot_done = 1'b0;
    logic [31:0] f_addr = '0, l_addr = '0, l_wdata = '0;
    logic        f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err, m_we;
    logic [31:0] f_rdata, l_rdata, m_wdata, m_rdata;
    logic [11:0] m_addr;
    logic        preload = 1'b1;
    logic [31:0] mem [4096];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    im_arb dut (
        .clk_i(clk), .reset_ni(reset_n),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
        .f_rdata_o(f_rdata), .f_err_o(f_err),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_boot_done_i(l_boot_done), .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid),
        .l_rdata_o(l_rdata), .l_err_o(l_err),
        .m_addr_o(m_addr), .m_we_o(m_we), .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
    );

    assign m_rdata = mem[m_addr];

    always @(posedge clk) begin
        if (preload)
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        else if (m_we)
            mem[m_addr] <= m_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lwe,
                         input logic [31:0] la, input logic [31:0] lwd, input logic bd);
        @(negedge clk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
        l_boot_done = bd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        fr;
        logic [31:0] fa;
        logic        lr;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        e_fg;
        logic        e_lg;
        logic [11:0] e_ma;
        logic        e_mwe;
        logic        e_lrv;
        logic [31:0] e_lrd;
        logic        e_lerr;
    } vec_t;

    vec_t vt [8];

    initial begin
        // BOOT-state vectors: loader only, fetch always refused.
        vt[0] = '{1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 32'h0, 1'b0};
        vt[1] = '{1'b1, 32'h3000, 1'b1, 1'b1, 32'h3000, 32'h3c010001,
                  1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 32'h0, 1'b0};
        vt[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4180, 32'h12345678,
                  1'b0, 1'b1, 12'd1120, 1'b1, 1'b0, 32'h0, 1'b0};
        vt[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3004, 32'h0,
                  1'b0, 1'b1, 12'd1, 1'b0, 1'b1, 32'hA000_0001, 1'b0};
        vt[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 32'hA000_0001, 1'b0};
        vt[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h4180, 32'h0,
                  1'b0, 1'b1, 12'd1120, 1'b0, 1'b1, 32'h12345678, 1'b0};
        vt[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2ffc, 32'hdeadbeef,
                  1'b0, 1'b1, 12'd4095, !CHK, CHK, CHK ? 32'h0 : 32'h12345678, CHK};
        vt[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3001, 32'h0,
                  1'b0, 1'b1, 12'd0, 1'b0, 1'b1, CHK ? 32'h0 : 32'h3c010001, CHK};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst f_rvalid", 32'(f_rvalid), 32'h0);
        chk("rst l_rvalid", 32'(l_rvalid), 32'h0);
        chk("rst f_rdata", f_rdata, 32'h0);
        chk("rst l_rdata", l_rdata, 32'h0);
        chk("rst f_err", 32'(f_err), 32'h0);
        chk("rst l_err", 32'(l_err), 32'h0);
        @(negedge clk);
        preload = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].fr, vt[i].fa, vt[i].lr, vt[i].lwe, vt[i].la, vt[i].lwd, 1'b0);
            chk($sformatf("v%0d f_gnt", i), 32'(f_gnt), 32'(vt[i].e_fg));
            chk($sformatf("v%0d l_gnt", i), 32'(l_gnt), 32'(vt[i].e_lg));
            chk($sformatf("v%0d m_addr", i), 32'(m_addr), 32'(vt[i].e_ma));
            chk($sformatf("v%0d m_we", i), 32'(m_we), 32'(vt[i].e_mwe));
            tick();
            chk($sformatf("v%0d l_rvalid", i), 32'(l_rvalid), 32'(vt[i].e_lrv));
            chk($sformatf("v%0d l_rdata", i), l_rdata, vt[i].e_lrd);
            chk($sformatf("v%0d l_err", i), 32'(l_err), 32'(vt[i].e_lerr));
            chk($sformatf("v%0d f_rvalid", i), 32'(f_rvalid), 32'h0);
        end

        // Fetch held in BOOT is never granted
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("boot wait f_gnt %0d", i), 32'(f_gnt), 32'h0);
            tick();
        end

        // boot_done together with a loader write: write lands, still BOOT this cycle
        drive(1'b1, 32'h3000, 1'b1, 1'b1, 32'h3008, 32'h0000_0055, 1'b1);
        chk("bd f_gnt", 32'(f_gnt), 32'h0);
        chk("bd l_gnt", 32'(l_gnt), 32'h1);
        chk("bd m_we", 32'(m_we), 32'h1);
        tick();

        drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("run f_gnt", 32'(f_gnt), 32'h1);
        chk("run m_addr", 32'(m_addr), 32'h0);
        tick();
        chk("fetch0 f_rvalid", 32'(f_rvalid), 32'h1);
        chk("fetch0 f_rdata", f_rdata, 32'h3c010001);
        chk("fetch0 f_err", 32'(f_err), 32'h0);

        drive(1'b1, 32'h3008, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("fetch bd-write f_rdata", f_rdata, 32'h0000_0055);

        drive(1'b1, 32'h4180, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("fetch4180 m_addr", 32'(m_addr), 32'd1120);
        tick();
        chk("fetch4180 f_rdata", f_rdata, 32'h12345678);

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("idle f_rvalid", 32'(f_rvalid), 32'h0);
        chk("idle f_rdata hold", f_rdata, 32'h12345678);

        drive(1'b1, 32'h2ffc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("low f_gnt", 32'(f_gnt), 32'h1);
        chk("low m_addr", 32'(m_addr), 32'd4095);
        chk("low m_we", 32'(m_we), 32'h0);
        tick();
        chk("low f_rvalid", 32'(f_rvalid), 32'h1);
        chk("low f_err", 32'(f_err), 32'(CHK));
        chk("low f_rdata", f_rdata, CHK ? 32'h0 : 32'hdeadbeef);

        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h3004, 32'h0, 1'b0);
        chk("run l alone l_gnt", 32'(l_gnt), 32'h1);
        chk("run l alone f_gnt", 32'(f_gnt), 32'h0);
        tick();
        chk("run l alone l_rdata", l_rdata, 32'hA000_0001);

        // Contention: loader wins once every STARVE_MAX+1 = 9 cycles
        for (int i = 0; i < 27; i++) begin
            drive(1'b1, 32'h3000, 1'b1, 1'b0, 32'h3008, 32'h0, 1'b0);
            chk($sformatf("starve %0d l_gnt", i), 32'(l_gnt), 32'(i % 9 == 8));
            chk($sformatf("starve %0d f_gnt", i), 32'(f_gnt), 32'(i % 9 != 8));
            tick();
            chk($sformatf("starve %0d l_rvalid", i), 32'(l_rvalid), 32'(i % 9 == 8));
            chk($sformatf("starve %0d f_rvalid", i), 32'(f_rvalid), 32'(i % 9 != 8));
            if (i % 9 == 8)
                chk($sformatf("starve %0d l_rdata", i), l_rdata, 32'h0000_0055);
        end

        // Reset one cycle after a fetch grant discards the response
        drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("pre-rst f_gnt", 32'(f_gnt), 32'h1);
        tick();
        chk("pre-rst f_rvalid", 32'(f_rvalid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid-rst f_rvalid", 32'(f_rvalid), 32'h0);
        chk("mid-rst f_rdata", f_rdata, 32'h0);
        chk("mid-rst f_gnt", 32'(f_gnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("post-rst f_gnt %0d", i), 32'(f_gnt), 32'h0);
            tick();
            chk($sformatf("post-rst f_rvalid %0d", i), 32'(f_rvalid), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
